// File: rtl/memory_arbiter.sv
// Round-robin arbiter that funnels NUM_MASTERS request ports onto one
// downstream memory port. Issued requests are tagged with their master index
// in a small in-order FIFO so that each downstream response is routed back to
// the master that issued it. At most DEPTH transactions may be in flight.
module memory_arbiter #(
   parameter int NUM_MASTERS   = 4,
   parameter int DATA_WIDTH    = 24,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DEPTH         = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,

   // Per-master request channel
   input  logic [NUM_MASTERS-1:0]               req_valid,
   output logic [NUM_MASTERS-1:0]               req_ready,
   input  logic [NUM_MASTERS-1:0]               req_write,
   input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] req_addr,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    req_wdata,

   // Per-master response channel (data bus shared)
   output logic [NUM_MASTERS-1:0]               rsp_valid,
   input  logic [NUM_MASTERS-1:0]               rsp_ready,
   output logic [DATA_WIDTH-1:0]                rsp_data,

   // Downstream request channel
   output logic                                 mem_req_valid,
   input  logic                                 mem_req_ready,
   output logic                                 mem_req_write,
   output logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
   output logic [DATA_WIDTH-1:0]                mem_req_wdata,

   // Downstream in-order response channel
   input  logic                                 mem_rsp_valid,
   output logic                                 mem_rsp_ready,
   input  logic [DATA_WIDTH-1:0]                mem_rsp_data,

   // Status
   output logic [$clog2(DEPTH):0]               outstanding,
   output logic                                 error
);

   // ------------------------------------------------------------------
   // Local sizing
   // ------------------------------------------------------------------
   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   // Resetting last_grant to the highest index gives master 0 first priority.
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_MASTERS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t state;
   state_t next_state;

   logic [IDX_W-1:0]         last_grant;

   // Hold registers: the accepted request, presented downstream in SEND.
   logic                     hold_write;
   logic [ADDRESS_WIDTH-1:0] hold_addr;
   logic [DATA_WIDTH-1:0]    hold_wdata;
   logic [IDX_W-1:0]         hold_idx;

   // Tag FIFO: master index of every issued, unanswered transaction.
   logic [IDX_W-1:0]         tag_mem [DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [CNT_W-1:0]         count;

   logic                     error_q;

   // ------------------------------------------------------------------
   // Internal combinational signals
   // ------------------------------------------------------------------
   logic [IDX_W-1:0]         rr_cand;
   logic [IDX_W-1:0]         winner;
   logic                     found;
   logic                     accept;
   logic                     push;
   logic                     pop;
   logic                     fifo_nonempty;
   logic [IDX_W-1:0]         head;

   // Round-robin search: first valid master after last_grant, with wrap.
   // NOTE: every variable written in an always_comb gets a default at the top
   // of the block; a path that leaves one unassigned would infer a latch.
   always_comb begin
      rr_cand = '0;
      winner  = '0;
      found   = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         rr_cand = IDX_W'((int'(last_grant) + k) % NUM_MASTERS);
         if (!found && req_valid[rr_cand]) begin
            found  = 1'b1;
            winner = rr_cand;
         end
      end
   end

   // Handshake qualifiers shared by the FSM and the datapath.
   always_comb begin
      accept        = (state == IDLE) && found && (count < FULL_COUNT);
      push          = (state == SEND) && mem_req_ready;
      fifo_nonempty = (count != '0);
      head          = tag_mem[rd_ptr];
      pop           = fifo_nonempty && mem_rsp_valid && rsp_ready[head];
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   // Advance the arbitration state; reset abandons any pending SEND.
   // NOTE: clocked blocks use non-blocking assignments so every register
   // samples pre-edge values regardless of statement or block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   // IDLE moves to SEND on acceptance; SEND returns once downstream takes it.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept)        next_state = SEND;
         SEND: if (mem_req_ready) next_state = IDLE;
         default:                 next_state = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   // Grant pulse in IDLE, downstream request in SEND; req_ready is also held
   // low while reset is asserted because req_valid may already be high.
   always_comb begin
      req_ready     = '0;
      mem_req_valid = (state == SEND);
      mem_req_write = hold_write;
      mem_req_addr  = hold_addr;
      mem_req_wdata = hold_wdata;
      if (rst_n && accept) begin
         req_ready[winner] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   // Capture the winning request and remember the grant for fairness.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= LAST_IDX;
         hold_write <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= '0;
         hold_idx   <= '0;
      end else if (accept) begin
         last_grant <= winner;
         hold_write <= req_write[winner];
         hold_addr  <= req_addr[winner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         hold_wdata <= req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
         hold_idx   <= winner;
      end
   end

   // Tag FIFO storage.
   // NOTE: the tag array has no reset; the pointers and count are reset, so
   // a stale entry is never read, and leaving storage unreset lets it map to
   // plain RAM/flops without a reset tree.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr] <= hold_idx;
      end
   end

   // Tag FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky flag: a downstream response arrived with nothing outstanding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error_q <= 1'b0;
      end else if (!fifo_nonempty && mem_rsp_valid) begin
         error_q <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Response routing
   // ------------------------------------------------------------------
   // Steer the downstream response to the master at the FIFO head; the data
   // bus is shared and passes through unqualified.
   always_comb begin
      rsp_valid     = '0;
      mem_rsp_ready = 1'b0;
      rsp_data      = mem_rsp_data;
      if (fifo_nonempty) begin
         rsp_valid[head] = mem_rsp_valid;
         mem_rsp_ready   = rsp_ready[head];
      end
   end

   assign outstanding = count;
   assign error       = error_q;

endmodule
